// File: rtl/time_disp_pkg.sv
// Shared types and helpers for the MM.SS display back-end.
// Build option TIME_DISP_LZ_BLANK_EN blanks a leading minutes-tens zero.
package time_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic [1:0] DIG_SO = 2'd0;
  localparam logic [1:0] DIG_ST = 2'd1;
  localparam logic [1:0] DIG_MO = 2'd2;
  localparam logic [1:0] DIG_MT = 2'd3;

  function automatic logic [6:0] seg7_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_display_bin2bcd6.sv
// 6-bit binary to two-digit BCD, shift-add-3, one bit per shift strobe.
// Stepped externally by load/shift strobes from the display FSM.
module bin2bcd6 (
  input  logic       clk_s,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [5:0] bin_i,
  output logic [7:0] bcd_o
);

  logic [5:0] bin_q;
  logic [7:0] bcd_q;
  logic [6:0] adj;

  // Tens never exceeds 3 before a shift, so its carry-out is unreachable
  always_comb begin
    adj[3:0] = bcd_q[3:0];
    adj[6:4] = bcd_q[6:4];
    if (bcd_q[3:0] >= 4'd5)
      adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5)
      adj[6:4] = bcd_q[6:4] + 3'd3;
  end

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
    end else if (shift_i) begin
      bin_q <= {bin_q[4:0], 1'b0};
      bcd_q <= {adj, bin_q[5]};
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/time_display.sv
// MM.SS display back-end: input sync, BCD conversion FSM, digit scan.
// Build option TIME_DISP_LZ_BLANK_EN blanks a leading minutes-tens zero.
module time_display
  import time_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk_s,
  input  logic       reset_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [11:0] sync1_q, sync2_q;
  logic [11:0] stab_q, last_q;
  logic        stable;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load, shift, commit;
  logic [7:0]  bcd_s, bcd_m;

  logic [3:0]  so_q, st_q, mo_q, mt_q;
  logic [CW-1:0] ref_q;
  logic [1:0]  idx_q;
  logic [3:0]  dig;
  logic        blank;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q  <= '0;
    end else begin
      sync1_q <= {min, sec};
      sync2_q <= sync1_q;
      stab_q  <= sync2_q;
    end
  end

  assign stable = (sync2_q == stab_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stable && (sync2_q != last_q))
          state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        cnt_d   = 3'd6;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1)
          state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load)
        last_q <= sync2_q;
    end
  end

  assign busy = (state_q != IDLE);

  bin2bcd6 u_sec (
    .clk_s   (clk_s),
    .reset_n (reset_n),
    .load_i  (load),
    .shift_i (shift),
    .bin_i   (sync2_q[5:0]),
    .bcd_o   (bcd_s)
  );

  bin2bcd6 u_min (
    .clk_s   (clk_s),
    .reset_n (reset_n),
    .load_i  (load),
    .shift_i (shift),
    .bin_i   (sync2_q[11:6]),
    .bcd_o   (bcd_m)
  );

  // All four digits update together so the display never tears
  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      so_q <= '0;
      st_q <= '0;
      mo_q <= '0;
      mt_q <= '0;
    end else if (commit) begin
      so_q <= bcd_s[3:0];
      st_q <= bcd_s[7:4];
      mo_q <= bcd_m[3:0];
      mt_q <= bcd_m[7:4];
    end
  end

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      ref_q <= '0;
      idx_q <= DIG_SO;
    end else if (ref_q == CW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  always_comb begin
    dig = so_q;
    unique case (idx_q)
      DIG_SO: dig = so_q;
      DIG_ST: dig = st_q;
      DIG_MO: dig = mo_q;
      DIG_MT: dig = mt_q;
      default: dig = so_q;
    endcase
  end

`ifdef TIME_DISP_LZ_BLANK_EN
  assign blank = (idx_q == DIG_MT) && (mt_q == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk_s or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= blank ? 4'hF : ~(4'b0001 << idx_q);
      seg_q <= blank ? 7'h7F : seg7_decode(dig);
      dp_q  <= (idx_q != DIG_MO);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: conversion, scan, reset, corners.
// Honours TIME_DISP_LZ_BLANK_EN for minutes-tens blanking.
module tb_time_display;

  logic       clk_s = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2;
  logic       busy, busy2;

  int total = 0;
  int bad = 0;

  always #5 clk_s = ~clk_s;

  time_display #(.REFRESH_DIV(4)) u_dut (
    .clk_s   (clk_s),
    .reset_n (reset_n),
    .sec     (sec),
    .min     (min),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  time_display #(.REFRESH_DIV(1024)) u_dut2 (
    .clk_s   (clk_s),
    .reset_n (reset_n),
    .sec     (sec),
    .min     (min),
    .an      (an2),
    .seg     (seg2),
    .dp      (dp2),
    .busy    (busy2)
  );

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (busy !== lvl && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      tick();
    end
  endtask

  logic [6:0] s0, s1, s2, s3, bseg;
  logic       d0, d2, seen3, blank;

  task automatic scan();
    s0 = 'x; s1 = 'x; s2 = 'x; s3 = 'x; bseg = 'x;
    d0 = 'x; d2 = 'x; seen3 = 0; blank = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      case (an)
        4'b1110: begin s0 = seg; d0 = dp; end
        4'b1101: s1 = seg;
        4'b1011: begin s2 = seg; d2 = dp; end
        4'b0111: begin s3 = seg; seen3 = 1; end
        4'b1111: begin bseg = seg; blank = 1; end
        default: ;
      endcase
    end
  endtask

  int n;
  logic [3:0] pat [4];

  initial begin
    // 1: reset
    tick(); tick();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, 7'h40);
    chk("rel_an2", an2, 4'b1110);

    // 2: 59:59
    min = 6'd59; sec = 6'd59;
    wait_busy(1'b1, "c59_start");
    busy_len(n);
    chk("c59_len", n, 8);
    scan();
    chk("c59_so", s0, 7'h10);
    chk("c59_st", s1, 7'h12);
    chk("c59_mo", s2, 7'h10);
    chk("c59_dp2", d2, 1'b0);
    chk("c59_dp0", d0, 1'b1);
    chk("c59_mt", s3, 7'h12);

    // 3: 00:63
    min = 6'd0; sec = 6'd63;
    wait_busy(1'b1, "c63_start");
    busy_len(n);
    scan();
    chk("c63_so", s0, 7'h30);
    chk("c63_st", s1, 7'h02);
    chk("c63_mo", s2, 7'h40);
`ifdef TIME_DISP_LZ_BLANK_EN
    chk("c63_blank", blank, 1'b1);
    chk("c63_bseg", bseg, 7'h7F);
    chk("c63_seen3", seen3, 1'b0);
`else
    chk("c63_seen3", seen3, 1'b1);
    chk("c63_mt", s3, 7'h40);
`endif

    // 4: change during SHIFT
    sec = 6'd10;
    wait_busy(1'b1, "c10_start");
    tick();
    sec = 6'd11;
    busy_len(n);
    chk("c10_so", u_dut.so_q, 4'd0);
    chk("c10_st", u_dut.st_q, 4'd1);
    wait_busy(1'b1, "c11_start");
    busy_len(n);
    chk("c11_len", n, 8);
    chk("c11_so", u_dut.so_q, 4'd1);
    scan();
    chk("c11_so_seg", s0, 7'h79);
    chk("c11_st_seg", s1, 7'h79);

    // 5: reset mid-conversion
    sec = 6'd0;
    wait_busy(1'b1, "c0_start");
    busy_len(n);
    sec = 6'd42;
    wait_busy(1'b1, "c42_start");
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_an", an, 4'hF);
    chk("mid_seg", seg, 7'h7F);
    chk("mid_dp", dp, 1'b1);
    tick();
    reset_n = 1'b1;
    wait_busy(1'b1, "r42_start");
    busy_len(n);
    chk("r42_len", n, 8);
    scan();
    chk("r42_so", s0, 7'h24);
    chk("r42_st", s1, 7'h19);

    // 6: scan period with REFRESH_DIV=1024
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    pat[0] = 4'b1110;
    pat[1] = 4'b1101;
    pat[2] = 4'b1011;
`ifdef TIME_DISP_LZ_BLANK_EN
    pat[3] = 4'b1111;
`else
    pat[3] = 4'b0111;
`endif
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("per_an%0d", k), an2, pat[k]);
      n = 0;
      while (an2 === pat[k] && n < 1100) begin
        n++;
        tick();
      end
      chk($sformatf("per_len%0d", k), n, 1024);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_display.md
# time_display

Display back-end for the seconds/minutes counter. Consumes the binary `sec` and `min` values, converts them to BCD with a sequential shift-add-3 engine, and time-multiplexes four active-low seven-segment digits in MM.SS layout. It is the stage directly downstream of the time counter and drives the board display pins.

## Interface

**Parameters**
- REFRESH_DIV, 1024: clk_s cycles each digit is held before the scan advances. Legal range is ≥2.

**Ports**
- clk_s, input, 1: block clock.
- reset_n, input, 1: reset, asynchronous, active-low; clock clk_s.
- sec, input, 6: binary seconds, 0–63 accepted. Asynchronous to clk_s.
- min, input, 6: binary minutes, 0–63 accepted. Asynchronous to clk_s.
- an, output, 4: digit enables, active-low. an[0] is the seconds ones digit, an[3] is the minutes tens digit.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low.
- busy, output, 1: high while a conversion is in progress.

## Operation

**Input capture**
- sec and min each pass through a two-flop synchronizer.
- A 12-bit stability register holds the previous synchronized value.
- The input is "stable" when the synchronized value equals the stability register.

**Conversion FSM states: IDLE, LOAD, SHIFT, COMMIT**
- IDLE → LOAD when the input is stable and the synchronized {min,sec} differs from the last captured value. Otherwise stay in IDLE.
- LOAD: capture {min,sec}, clear the BCD scratch registers, set shift count = 6. Go to SHIFT.
- SHIFT: both values convert in parallel, one bit per cycle.
  - Add 3 to any nibble ≥5.
  - Then shift left, bringing in the binary MSB.
  - Decrement the count; go to COMMIT after the 6th shift.
- COMMIT: write all four digit registers {mt,mo,st,so} in the same cycle, so there is never a torn display. Go to IDLE.
- busy = 1 in LOAD, SHIFT and COMMIT.
- Input changes during a conversion are ignored. They are picked up on the next IDLE evaluation.
- Values 60–63 are converted faithfully (e.g. 63 → 6,3). No clamping.

**Scan**
- The refresh counter counts 0..REFRESH_DIV-1 and wraps.
- On wrap, the digit index advances 0→1→2→3→0.
- seg shows the decode of the selected digit register.
- dp = 0 only while the index is 2 (separator between MM and SS). Otherwise dp = 1.

**Segment codes** (seg value for each digit)
- 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19
- 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10

## Timing

**Reset values**
- Outputs: an = 4'b1111, seg = 7'h7F, dp = 1, busy = 0.
- Internal: digit registers = 0, last captured = 0, refresh counter = 0, index = 0, FSM = IDLE.

**After reset release**
- First clk_s edge: an = 4'b1110, seg = 0x40.
- an, seg and dp are all registered and always change on the same edge.

**Latency**
- From a capture in LOAD to updated digit registers: 8 cycles (LOAD 1 + SHIFT 6 + COMMIT 1).
- From an input change to updated digit registers: ≤12 cycles (2 sync + 1 stability + 1 IDLE decision + 8).
- seg reflects new digit registers on the first edge after COMMIT at which that digit is selected.

**Boundary and corner behaviour**
- A scan-index wrap coinciding with COMMIT: the new index shows the new data on the next edge.
- Reset asserted mid-conversion: the FSM aborts immediately and all values return to reset state. The old digits are not retained.
- Input equal to the last captured value: no conversion starts and busy stays 0.

## Configuration

- TIME_DISP_LZ_BLANK_EN defined: when the minutes tens digit is 0, an[3] stays 1 during index 3 and seg = 0x7F (leading-zero blank).
- Not defined: the minutes tens digit always displays, including 0.
- All other behaviour is identical in both builds.

## Structure

- Package time_disp_pkg contains:
  - state enum {IDLE, LOAD, SHIFT, COMMIT};
  - the digit index constants DIG_SO, DIG_ST, DIG_MO, DIG_MT;
  - function seg7_decode(4-bit) → 7-bit, with the table above; codes 10–15 → 0x7F.
- Sub-module bin2bcd6: a 6-bit-to-8-bit BCD shift-add-3 datapath stepped by the top FSM through load/shift strobes. Instantiated twice, once for sec and once for min.
- The FSM, synchronizers, scan counter and output registers live in the top level.

## Test plan

Use REFRESH_DIV = 4 unless stated otherwise.

1. **Reset:** hold reset_n = 0 → an = 1111, seg = 0x7F, dp = 1. Release → the next edge gives an = 1110, seg = 0x40.
2. **Normal conversion:** min = 59, sec = 59 stable → busy high for exactly 8 cycles. Scan then shows an=1110 seg=0x10, an=1101 seg=0x12, an=1011 seg=0x10 with dp=0, an=0111 seg=0x12.
3. **Out-of-range input:** sec = 63, min = 0 → seconds digits show 0x30 (ones, 3) and 0x02 (tens, 6). With TIME_DISP_LZ_BLANK_EN, index 3 gives an = 1111, seg = 0x7F. Without the macro, an = 0111, seg = 0x40.
4. **Change mid-conversion:** sec changes 10 → 11 during SHIFT → the display first commits 10, then a second conversion starts and commits 11. No mixed digits appear.
5. **Reset mid-conversion:** assert reset_n in SHIFT after a 0 → 42 change → all outputs return to reset values. After release, the block re-converts 42 and commits it.
6. **Scan period:** REFRESH_DIV = 1024 → each an pattern is held exactly 1024 cycles in the order 1110, 1101, 1011, 0111.
